// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I instruction-decode stage with ID/EX pipeline register
//
// Decodes one fetched instruction per handshake into ALU control fields,
// register addresses, immediate and datapath controls. It then registers the
// result for the execute stage.
//
// Optional macro ID_SKID_EN: adds a one-entry skid buffer in front of the
// ID/EX register. in_ready then comes from a flop (!skid_full), not from
// out_ready/stall.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid/in_ready      fetch handshake; in_pc, in_instr carry the instruction
//   stall                  hazard hold; flush kills in-flight contents
//   out_valid/out_ready    execute handshake
//   out_pc                 registered PC
//   alu_op, funct7, shamt, is_r_type   ALU control fields
//   rs1, rs2, rd, imm, use_imm         operand selection
//   reg_write, mem_read, mem_write, branch, jal, jalr, lui, auipc, illegal
module id_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [31:0]     RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_pc,
  input  logic [31:0]     in_instr,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [2:0]      alu_op,
  output logic [6:0]      funct7,
  output logic [4:0]      shamt,
  output logic            is_r_type,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jal,
  output logic            jalr,
  output logic            lui,
  output logic            auipc,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] ALU_ADD    = 3'b000;

  typedef struct packed {
    logic [2:0]      alu_op;
    logic [6:0]      funct7;
    logic [4:0]      shamt;
    logic            is_r_type;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } dec_t;

  logic        r_valid;
  logic [31:0] r_pc;
  dec_t        r_dec;
  dec_t        w_dec;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_writes;
  logic        w_accept;
  logic        w_main_free;

`ifdef ID_SKID_EN
  logic        r_skid_full;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;

  // The skid entry is older than anything on the input, so it decodes first.
  assign w_instr     = r_skid_full ? r_skid_instr : in_instr;
  assign w_pc        = r_skid_full ? r_skid_pc    : in_pc;
  assign in_ready    = !r_skid_full;
`else
  assign w_instr     = in_instr;
  assign w_pc        = in_pc;
  assign in_ready    = w_main_free;
`endif

  assign w_main_free = !stall && (!r_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_f3        = w_instr[14:12];
  assign w_f7        = w_instr[31:25];

  always_comb begin
    w_dec         = '0;
    w_writes      = 1'b0;
    w_dec.rs1     = w_instr[19:15];
    w_dec.rd      = w_instr[11:7];
    w_dec.use_imm = 1'b1;
    w_dec.alu_op  = ALU_ADD;
    case (w_instr[6:0])
      OPC_OP: begin
        w_dec.is_r_type = 1'b1;
        w_dec.alu_op    = w_f3;
        w_dec.funct7    = w_f7;
        w_dec.rs2       = w_instr[24:20];
        w_dec.use_imm   = 1'b0;
        w_writes        = 1'b1;
        // Only SUB and SRA use the alternate funct7 encoding.
        w_dec.illegal   = !((w_f7 == 7'h00) ||
                            (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        w_dec.alu_op = w_f3;
        w_dec.funct7 = w_f7;
        w_dec.imm    = XLEN'($signed(w_instr[31:20]));
        w_writes     = 1'b1;
        if (w_f3 == 3'b001) begin
          w_dec.shamt   = w_instr[24:20];
          w_dec.illegal = (w_f7 != 7'h00);
        end else if (w_f3 == 3'b101) begin
          w_dec.shamt   = w_instr[24:20];
          w_dec.illegal = !(w_f7 == 7'h00 || w_f7 == 7'h20);
        end
      end
      OPC_LOAD: begin
        w_dec.imm      = XLEN'($signed(w_instr[31:20]));
        w_dec.mem_read = 1'b1;
        w_writes       = 1'b1;
      end
      OPC_STORE: begin
        w_dec.imm       = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
        w_dec.rs2       = w_instr[24:20];
        w_dec.rd        = 5'd0;
        w_dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.imm     = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25],
                                       w_instr[11:8], 1'b0}));
        w_dec.rs2     = w_instr[24:20];
        w_dec.rd      = 5'd0;
        w_dec.use_imm = 1'b0;
        w_dec.branch  = 1'b1;
      end
      OPC_JAL: begin
        w_dec.imm = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20],
                                   w_instr[30:21], 1'b0}));
        w_dec.rs1 = 5'd0;
        w_dec.jal = 1'b1;
        w_writes  = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm  = XLEN'($signed(w_instr[31:20]));
        w_dec.jalr = 1'b1;
        w_writes   = 1'b1;
      end
      OPC_LUI: begin
        // rs1 = x0 lets the ALU compute 0 + imm.
        w_dec.imm = XLEN'($signed({w_instr[31:12], 12'b0}));
        w_dec.rs1 = 5'd0;
        w_dec.lui = 1'b1;
        w_writes  = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.imm   = XLEN'($signed({w_instr[31:12], 12'b0}));
        w_dec.rs1   = 5'd0;
        w_dec.auipc = 1'b1;
        w_writes    = 1'b1;
      end
      default: begin
        w_dec.illegal = 1'b1;
        w_dec.rs1     = 5'd0;
        w_dec.rd      = 5'd0;
      end
    endcase
    // Illegal instructions still flow to EX for the trap, but with no side effects.
    w_dec.reg_write = w_writes && (w_dec.rd != 5'd0) && !w_dec.illegal;
    if (w_dec.illegal) begin
      w_dec.mem_read  = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jal       = 1'b0;
      w_dec.jalr      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= RESET_PC;
      r_dec        <= '0;
`ifdef ID_SKID_EN
      r_skid_full  <= 1'b0;
      r_skid_pc    <= 32'd0;
      r_skid_instr <= 32'd0;
`endif
    end else if (flush) begin
      r_valid      <= 1'b0;
`ifdef ID_SKID_EN
      r_skid_full  <= 1'b0;
`endif
    end else begin
`ifdef ID_SKID_EN
      if (w_main_free) begin
        if (r_skid_full || in_valid) begin
          r_valid     <= 1'b1;
          r_pc        <= w_pc;
          r_dec       <= w_dec;
          r_skid_full <= 1'b0;
        end else begin
          r_valid     <= 1'b0;
        end
      end else begin
        // Stall with a consumer ready drains the register as a bubble.
        if (out_ready) begin
          r_valid <= 1'b0;
        end
        if (w_accept) begin
          r_skid_full  <= 1'b1;
          r_skid_pc    <= in_pc;
          r_skid_instr <= in_instr;
        end
      end
`else
      if (w_accept) begin
        r_valid <= 1'b1;
        r_pc    <= w_pc;
        r_dec   <= w_dec;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
`endif
    end
  end

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign alu_op    = r_dec.alu_op;
  assign funct7    = r_dec.funct7;
  assign shamt     = r_dec.shamt;
  assign is_r_type = r_dec.is_r_type;
  assign rs1       = r_dec.rs1;
  assign rs2       = r_dec.rs2;
  assign rd        = r_dec.rd;
  assign imm       = r_dec.imm;
  assign use_imm   = r_dec.use_imm;
  assign reg_write = r_dec.reg_write;
  assign mem_read  = r_dec.mem_read;
  assign mem_write = r_dec.mem_write;
  assign branch    = r_dec.branch;
  assign jal       = r_dec.jal;
  assign jalr      = r_dec.jalr;
  assign lui       = r_dec.lui;
  assign auipc     = r_dec.auipc;
  assign illegal   = r_dec.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
module tb_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  alu_op;
    logic [6:0]  funct7;
    logic [4:0]  shamt;
    logic        is_r_type;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic [7:0]  ctl;      // reg_write mem_read mem_write branch jal jalr lui auipc
    logic        illegal;
  } exp_t;

  typedef struct {
    exp_t  e;
    exp_t  m;
    string nm;
  } sb_t;

  localparam exp_t M_ALL  = '1;
  localparam exp_t M_CTRL = {32'hFFFF_FFFF, 3'b0, 7'b0, 5'b0, 1'b0, 15'b0, 32'b0,
                             1'b0, 8'b1111_1100, 1'b1};
  localparam exp_t M_NORS = ~{32'b0, 3'b0, 7'b0, 5'b0, 1'b0, 5'h1F, 5'h1F, 5'b0,
                              32'b0, 1'b0, 8'b0, 1'b0};

  logic        clk, rst, in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, imm;
  logic [2:0]  alu_op;
  logic [6:0]  funct7;
  logic [4:0]  shamt, rs1, rs2, rd;
  logic        is_r_type, use_imm, reg_write, mem_read, mem_write;
  logic        branch, jal, jalr, lui, auipc, illegal;

  int   n_tests = 0;
  int   n_fail  = 0;
  sb_t  q[$];
  exp_t snap;

  id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .alu_op(alu_op), .funct7(funct7), .shamt(shamt), .is_r_type(is_r_type),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jal(jal), .jalr(jalr), .lui(lui), .auipc(auipc),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t get_out();
    return {out_pc, alu_op, funct7, shamt, is_r_type, rs1, rs2, rd, imm, use_imm,
            reg_write, mem_read, mem_write, branch, jal, jalr, lui, auipc, illegal};
  endfunction

  function automatic exp_t mk(input logic [2:0] a, input logic [6:0] f7,
                              input logic [4:0] sh, input logic r,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] d, input logic [31:0] im,
                              input logic ui, input logic [7:0] ctl,
                              input logic ill);
    return {32'h0, a, f7, sh, r, s1, s2, d, im, ui, ctl, ill};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one instruction; push its expectation once the handshake is seen
  // (unless a flush in the same cycle kills it).
  task automatic send(input logic [31:0] pc, input logic [31:0] ins,
                      input exp_t e, input exp_t m, input string nm);
    sb_t s;
    bit  ok = 0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept: in_ready never rose within 50 cycles", nm);
    end else if (!flush) begin
      s.e    = e;
      s.e.pc = pc;
      s.m    = m;
      s.nm   = nm;
      q.push_back(s);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: every transfer on the output side is popped and compared.
  initial begin
    sb_t  s;
    exp_t a;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        a = get_out();
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", a);
        end else begin
          s = q.pop_front();
          if (((a ^ s.e) & s.m) != '0) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (mask %h)", s.nm, a, s.e, s.m);
          end
        end
      end
    end
  end

  initial begin
    exp_t v;
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_pc", 128'(out_pc), 128'(RST_PC));
    v = get_out();
    v.pc = '0;
    check("rst_fields", 128'(v), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // Decode vectors, back to back
    send(32'h100, 32'h002081B3, mk(3'b000, 7'h00, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "add");
    send(32'h104, 32'h402081B3, mk(3'b000, 7'h20, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "sub");
    send(32'h108, 32'h40335293, mk(3'b101, 7'h20, 5'd3, 0, 5'd6, 5'd0, 5'd5, 32'h403, 1, 8'b1000_0000, 0), M_ALL, "srai");
    send(32'h10C, 32'hFFC12083, mk(3'b000, 7'h00, 5'd0, 0, 5'd2, 5'd0, 5'd1, 32'hFFFF_FFFC, 1, 8'b1100_0000, 0), M_ALL, "lw");
    send(32'h110, 32'h0000007F, mk(3'b000, 7'h00, 5'd0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 8'b0000_0000, 1), M_CTRL, "unknown_opc");
    send(32'h114, 32'h00512423, mk(3'b000, 7'h00, 5'd0, 0, 5'd2, 5'd5, 5'd0, 32'h8, 1, 8'b0010_0000, 0), M_ALL, "sw");
    send(32'h118, 32'hFE208CE3, mk(3'b000, 7'h00, 5'd0, 0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 0, 8'b0001_0000, 0), M_ALL, "beq");
    send(32'h11C, 32'h123453B7, mk(3'b000, 7'h00, 5'd0, 0, 5'd0, 5'd0, 5'd7, 32'h1234_5000, 1, 8'b1000_0010, 0), M_ALL, "lui");
    send(32'h120, 32'h010000EF, mk(3'b000, 7'h00, 5'd0, 0, 5'd0, 5'd0, 5'd1, 32'h10, 1, 8'b1000_1000, 0), M_NORS, "jal");
    send(32'h124, 32'h202081B3, mk(3'b000, 7'h00, 5'd0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 8'b0000_0000, 1), M_CTRL, "op_bad_f7");
    send(32'h128, 32'h41F09093, mk(3'b000, 7'h00, 5'd0, 0, 5'd0, 5'd0, 5'd0, 32'h0, 0, 8'b0000_0000, 1), M_CTRL, "slli_bad_f7");
    send(32'h12C, 32'h00208033, mk(3'b000, 7'h00, 5'd0, 1, 5'd1, 5'd2, 5'd0, 32'h0, 0, 8'b0000_0000, 0), M_ALL, "add_x0");
    send(32'h130, 32'hFFF00093, mk(3'b000, 7'h7F, 5'd0, 0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1, 8'b1000_0000, 0), M_ALL, "addi_m1");
    idle(3);

    // Backpressure: outputs hold and nothing is lost or duplicated
    out_ready = 1'b0;
    send(32'h200, 32'h002081B3, mk(3'b000, 7'h00, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "bp_first");
    fork
      send(32'h204, 32'h402081B3, mk(3'b000, 7'h20, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "bp_second");
      begin
        @(negedge clk);
        snap = get_out();
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", 128'(in_ready), 128'(0));
          check("bp_valid", 128'(out_valid), 128'(1));
          check("bp_stable", 128'(get_out()), 128'(snap));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle(3);

    // Flush in the same cycle as an accept drops the instruction
    flush = 1'b1;
    send(32'h300, 32'h002081B3, mk(3'b000, 7'h00, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "flushed");
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 128'(out_valid), 128'(0));
    idle(1);

    // Stall with a ready consumer inserts a bubble
    send(32'h400, 32'hFFC12083, mk(3'b000, 7'h00, 5'd0, 0, 5'd2, 5'd0, 5'd1, 32'hFFFF_FFFC, 1, 8'b1100_0000, 0), M_ALL, "pre_stall");
    stall = 1'b1;
    @(negedge clk);
`ifdef ID_SKID_EN
    check("stall_in_ready", 128'(in_ready), 128'(1));
`else
    check("stall_in_ready", 128'(in_ready), 128'(0));
`endif
    @(negedge clk);
    check("bubble_valid", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    stall = 1'b0;
    idle(2);

    // A, B, C back to back while out_ready drops for single cycles
    fork
      begin
        send(32'h500, 32'h002081B3, mk(3'b000, 7'h00, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "order_a");
        send(32'h504, 32'h40335293, mk(3'b101, 7'h20, 5'd3, 0, 5'd6, 5'd0, 5'd5, 32'h403, 1, 8'b1000_0000, 0), M_ALL, "order_b");
        send(32'h508, 32'h00512423, mk(3'b000, 7'h00, 5'd0, 0, 5'd2, 5'd5, 5'd0, 32'h8, 1, 8'b0010_0000, 0), M_ALL, "order_c");
      end
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          out_ready = 1'b0;
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
    join
    idle(4);

    // Asynchronous reset mid-stream, checked before any clock edge
    out_ready = 1'b0;
    send(32'h600, 32'h002081B3, mk(3'b000, 7'h00, 5'd0, 1, 5'd1, 5'd2, 5'd3, 32'h0, 0, 8'b1000_0000, 0), M_ALL, "killed_by_rst");
    @(negedge clk);
    check("pre_rst_valid", 128'(out_valid), 128'(1));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(out_valid), 128'(0));
    check("async_rst_pc", 128'(out_pc), 128'(RST_PC));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    q.delete();
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);

    send(32'h700, 32'hFE208CE3, mk(3'b000, 7'h00, 5'd0, 0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFF8, 0, 8'b0001_0000, 0), M_ALL, "post_rst");

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 128'(q.size()), 128'(0));
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
